// File: rtl/weight_mem_loader_pkg.sv
// Shared types for the weight-memory loader: FSM state encoding and
// the write-address width rule shared with the read side.
package weight_mem_loader_pkg;

    localparam int STATE_W    = 2;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // The write address carries one extra bit to match the read-port address.
    function automatic int waddr_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/weight_addr_counter.sv
// Write-address counter with synchronous clear, increment and a terminal
// flag at numWeight-1; shared by the weight and bias loaders.
module weight_addr_counter
    import weight_mem_loader_pkg::*;
#(
    parameter int addressWidth = DEF_ADDR_W,
    parameter int numWeight    = 784
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear_i,
    input  logic                                 incr_i,
    output logic [waddr_width(addressWidth)-1:0] count_o,
    output logic                                 term_o
);

    localparam int CW = waddr_width(addressWidth);
    localparam logic [CW-1:0] LAST = CW'(numWeight - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == LAST);

endmodule

// File: rtl/weight_mem_loader.sv
// Turns a valid/ready weight stream into one-hot writes for one neuron's
// weight memory, checking the vector length against numWeight.
module weight_mem_loader
    import weight_mem_loader_pkg::*;
#(
    parameter int numNeurons   = 32,
    parameter int addressWidth = DEF_ADDR_W,
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784,
    parameter int selWidth     = $clog2(numNeurons)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [selWidth-1:0]                  neuron_sel,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [dataWidth-1:0]                 s_data,
    input  logic                                 s_last,
    output logic [numNeurons-1:0]                wen,
    output logic [waddr_width(addressWidth)-1:0] waddr,
    output logic [dataWidth-1:0]                 win,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int AW = waddr_width(addressWidth);
    localparam logic [selWidth:0]     SEL_LIM = (selWidth + 1)'(numNeurons);
    localparam logic [numNeurons-1:0] WEN_ONE = numNeurons'(1);

    state_t                state_q, state_d;
    logic [selWidth-1:0]   sel_q, sel_d;
    logic [numNeurons-1:0] wen_q, wen_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [dataWidth-1:0]  win_q, win_d;
    logic                  ready_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  hs;
    logic                  cnt_clear, cnt_incr, cnt_term;
    logic [AW-1:0]         cnt;

    assign hs = s_valid && ready_q;

    weight_addr_counter #(
        .addressWidth (addressWidth),
        .numWeight    (numWeight)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cnt_clear),
        .incr_i  (cnt_incr),
        .count_o (cnt),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wen_d     = '0;
        waddr_d   = waddr_q;
        win_d     = win_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if ({1'b0, neuron_sel} >= SEL_LIM) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d     = neuron_sel;
                        cnt_clear = 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wen_d    = WEN_ONE << sel_q;
                    waddr_d  = cnt;
                    win_d    = s_data;
                    cnt_incr = 1'b1;
                    if (s_last) begin
                        state_d = S_IDLE;
                        if (cnt_term) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt_term) begin
                        // Vector longer than numWeight: swallow the tail.
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (hs && s_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            wen_q   <= '0;
            waddr_q <= '0;
            win_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            win_q   <= win_d;
            ready_q <= (state_d != S_IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s_ready = ready_q;
    assign busy    = ready_q;
    assign wen     = wen_q;
    assign waddr   = waddr_q;
    assign win     = win_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
